eth_rx_frame_ctrl: RTL

Serial receive controller for the Ethernet frame path. It consumes a one-bit-per-cycle line stream and locks onto the preamble/SFD. It then sequences capture of the destination MAC, source MAC, length and payload, and checks the FCS with a serial CRC-32. It presents header fields and payload bytes to downstream logic, and ends every frame with exactly one done/error indication.

---
 rtl/eth_rx_frame_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_frame_ctrl.sv
// Serial Ethernet receive controller: preamble/SFD hunt, header and payload capture,
// and FCS check with a serial CRC-32. Every frame ends in one frame_done or one err pulse.
module eth_rx_frame_ctrl #(
  parameter int MAX_LEN_BYTES     = 1500,
  parameter int MIN_PAYLOAD_BYTES = 46,
  parameter int PREAMBLE_BYTES    = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic        busy,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] frame_len,
  output logic        hdr_valid,
  output logic [7:0]  pay_data,
  output logic        pay_valid,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        err,
  output logic [1:0]  err_code
);

  // state   | meaning
  // HUNT    | sliding search for preamble + SFD
  // DST     | 48-bit destination MAC
  // SRC     | 48-bit source MAC
  // LEN     | 16-bit length field, validated on its last bit
  // PAYLOAD | real payload bytes, strobed on pay_valid
  // PAD     | pad bytes up to the minimum payload, CRC only
  // FCS     | 32-bit frame check sequence
  typedef enum logic [2:0] {HUNT, DST, SRC, LEN, PAYLOAD, PAD, FCS} state_t;

  localparam int          SFD_BITS  = (PREAMBLE_BYTES + 1) * 8;
  localparam logic [SFD_BITS-1:0] SFD = {{PREAMBLE_BYTES{8'hAA}}, 8'hAB};
  localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESID = 32'hC704_DD7B;
  localparam logic [15:0] MAX_LEN   = 16'(MAX_LEN_BYTES);
  localparam logic [15:0] MIN_PAY   = 16'(MIN_PAYLOAD_BYTES);
  localparam logic [15:0] TYPE_MIN  = 16'h0600;

  state_t      state;
  logic [63:0] sr;
  logic [31:0] crc;
  logic [2:0]  bit_cnt;
  logic [10:0] byte_cnt;
  logic [10:0] pad_bytes;
  logic [14:0] len_sr;
  logic [6:0]  byte_sr;

  logic [63:0] sr_next;
  logic [31:0] crc_next;
  logic [15:0] len_next;
  logic [15:0] pad_calc;
  logic        sfd_hit;
  logic        byte_end;
  logic        field_end;
  logic        len_bad;
  logic        len_type;

  always_comb begin
    sr_next   = {sr[62:0], bit_in};
    crc_next  = {crc[30:0], 1'b0} ^ ({32{crc[31] ^ bit_in}} & CRC_POLY);
    len_next  = {len_sr, bit_in};
    pad_calc  = (len_next < MIN_PAY) ? (MIN_PAY - len_next) : 16'd0;
    sfd_hit   = (sr_next[SFD_BITS-1:0] == SFD);
    byte_end  = (bit_cnt == 3'd7);
    field_end = byte_end && (byte_cnt == 11'd0);
    len_type  = (len_next >= TYPE_MIN);
    len_bad   = (len_next == 16'd0) || ((len_next > MAX_LEN) && !len_type);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      sr         <= '0;
      crc        <= CRC_INIT;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      pad_bytes  <= '0;
      len_sr     <= '0;
      byte_sr    <= '0;
      busy       <= 1'b0;
      dst_mac    <= '0;
      src_mac    <= '0;
      frame_len  <= '0;
      hdr_valid  <= 1'b0;
      pay_data   <= '0;
      pay_valid  <= 1'b0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      pay_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (bit_valid) begin
        // byte_cnt is a per-field down-counter; field transitions below reload it
        if (state != HUNT) begin
          crc     <= crc_next;
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_end && byte_cnt != 11'd0) byte_cnt <= byte_cnt - 11'd1;
        end
        case (state)
          HUNT: begin
            sr <= sr_next;
            if (sfd_hit) begin
              state     <= DST;
              sr        <= '0;
              busy      <= 1'b1;
              hdr_valid <= 1'b0;
              crc       <= CRC_INIT;
              bit_cnt   <= '0;
              byte_cnt  <= 11'd5;
            end
          end
          DST: begin
            dst_mac <= {dst_mac[46:0], bit_in};
            if (field_end) begin
              state    <= SRC;
              byte_cnt <= 11'd5;
            end
          end
          SRC: begin
            src_mac <= {src_mac[46:0], bit_in};
            if (field_end) begin
              state    <= LEN;
              byte_cnt <= 11'd1;
            end
          end
          LEN: begin
            len_sr <= len_next[14:0];
            if (field_end) begin
              frame_len <= len_next;
              hdr_valid <= 1'b1;
              if (len_bad || len_type) begin
                state    <= HUNT;
                busy     <= 1'b0;
                err      <= 1'b1;
                err_code <= len_type ? 2'd2 : 2'd1;
              end else begin
                state     <= PAYLOAD;
                byte_cnt  <= len_next[10:0] - 11'd1;
                pad_bytes <= pad_calc[10:0];
              end
            end
          end
          PAYLOAD: begin
            byte_sr <= {byte_sr[5:0], bit_in};
            if (byte_end) begin
              pay_data  <= {byte_sr, bit_in};
              pay_valid <= 1'b1;
              if (byte_cnt == 11'd0) begin
                if (pad_bytes != 11'd0) begin
                  state    <= PAD;
                  byte_cnt <= pad_bytes - 11'd1;
                end else begin
                  state    <= FCS;
                  byte_cnt <= 11'd3;
                end
              end
            end
          end
          PAD: begin
            if (field_end) begin
              state    <= FCS;
              byte_cnt <= 11'd3;
            end
          end
          FCS: begin
            if (field_end) begin
              state      <= HUNT;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              crc_ok     <= (crc_next == CRC_RESID);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
